fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 16-bit pipelined CPU: owns the PC register and the IF/ID pipeline register.
//  Issues instruction-memory reads over a req/ready handshake and advances PC by +2.
//  Accepts redirects from the branch/PC-control logic in ID (redirect_pc = taken target).
//  Detects HLT and parks the front end until reset or redirect.
// PARAMETERS
//  RESET_PC     16'h0000  PC loaded on reset
//  HALT_OPCODE  4'hF      instr[15:12] value that marks HLT
//  NOP_INSTR    16'h0000  value driven on if_id_instr while if_id_valid=0
// PORTS
//  clk             in   1   clock; all state updates on posedge
//  rst_n           in   1   reset, asynchronous, active-low
//  stall           in   1   hazard unit: hold PC and IF/ID this cycle
//  redirect_valid  in   1   taken branch/jump resolved in ID
//  redirect_pc     in   16  new PC when redirect_valid=1
//  imem_req        out  1   read request to instruction memory/cache
//  imem_addr       out  16  read address (= PC register)
//  imem_ready      in   1   imem_rdata valid this cycle for imem_addr
//  imem_rdata      in   16  instruction word
//  if_id_valid     out  1   IF/ID holds a real instruction
//  if_id_instr     out  16  instruction to decode
//  if_id_pc_plus2  out  16  PC+2 of that instruction (branch base for PC control)
//  halted          out  1   front end parked on HLT
// BEHAVIOUR
//  Reset (async, rst_n=0): pc=RESET_PC, state=IDLE, if_id_valid=0, if_id_instr=NOP_INSTR,
//   if_id_pc_plus2=0, halted=0, imem_req=0. Outputs stable the whole time rst_n=0.
//  States: IDLE -> FETCH (unconditional, 1 cycle after reset release); FETCH -> HALT; HALT -> FETCH.
//  imem_addr = pc (registered); imem_req = (state==FETCH), combinational from state.
//  Priority per cycle: redirect_valid > stall > fetch result.
//  FETCH, redirect_valid=1 (any imem_ready): pc<={redirect_pc[15:1],1'b0}; if_id_valid<=0,
//   if_id_instr<=NOP_INSTR; imem_rdata this cycle discarded. Memory accepts an addr change while req held.
//  FETCH, stall=1, no redirect: pc and IF/ID hold; any returned imem_rdata dropped (refetched later).
//  FETCH, imem_ready=1, no stall/redirect: if_id_instr<=imem_rdata, if_id_valid<=1,
//   if_id_pc_plus2<=pc+2, pc<=pc+2. Latency: addr issued -> IF/ID valid one edge after ready.
//  FETCH, imem_ready=0, no stall/redirect: bubble (if_id_valid<=0, instr<=NOP_INSTR); pc holds.
//  HLT: accepted word with imem_rdata[15:12]==HALT_OPCODE is passed to IF/ID (valid=1) with
//   pc_plus2 as usual, but pc NOT incremented; state<=HALT; halted<=1 same edge.
//  HALT: imem_req=0; pc holds; IF/ID keeps HLT while stall=1, else becomes bubble; halted=1.
//  HALT, redirect_valid=1: HLT was wrong-path -> halted<=0, state<=FETCH, pc<=redirect_pc, IF/ID bubble.
//  Arithmetic: 16-bit, mod 2^16; pc 16'hFFFE + 2 -> 16'h0000, no flag, no trap.
//  redirect_pc bit0 forced 0; pc[0] is always 0.
//  Reset asserted mid-fetch: outstanding request abandoned, everything returns to reset values.
// TESTING
//  1 Reset, imem_ready=1 every cycle, words 0x1111,0x2222 -> IF/ID valid 0x1111/pc_plus2 0x0002, then 0x2222/0x0004.
//  2 imem_ready low 3 cycles at pc=0x0010 -> 3 bubbles, imem_addr stays 0x0010, then valid word, pc_plus2=0x0012.
//  3 stall=1 for 2 cycles with imem_ready=1 -> IF/ID and pc frozen, word refetched after stall drops.
//  4 redirect_valid=1, redirect_pc=0x0041 with stall=1 and imem_ready=1 -> pc=0x0040, IF/ID bubble next cycle.
//  5 fetch 0xF000 at pc=0x0020 -> IF/ID 0xF000 valid, halted=1, imem_req=0, pc stays 0x0020;
//    redirect to 0x0100 -> halted=0, fetch resumes at 0x0100.
//  6 pc=0xFFFE, fetch accepted -> if_id_pc_plus2=0x0000, next imem_addr=0x0000; async reset mid-wait -> all reset values.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory read bus between the fetch stage and the instruction
// memory or cache.
//   imem_req    fetch -> mem  read request, held while waiting for data
//   imem_addr   fetch -> mem  read address; it may change while the request is held
//   imem_ready  mem -> fetch  imem_rdata is valid this cycle for imem_addr
//   imem_rdata  mem -> fetch  16-bit instruction word
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ready, input imem_rdata);
  modport slave  (input  imem_req, input imem_addr,
                  output imem_ready, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage of the 16-bit pipelined CPU. It owns the PC and the IF/ID pipeline
// register, and it issues instruction reads over the imem interface.
// Each accepted word advances the PC by 2. A taken redirect from ID replaces
// the PC. An HLT word parks the front end until reset or a redirect arrives.
// Ports:
//   clk, rst_n       clock; asynchronous active-low reset
//   stall            hazard unit: hold the PC and IF/ID this cycle
//   redirect_valid   taken branch or jump resolved in ID
//   redirect_pc      new PC when redirect_valid=1 (bit 0 is ignored)
//   imem             instruction-memory read bus (master side)
//   if_id_valid      IF/ID holds a real instruction
//   if_id_instr      instruction to decode (NOP_INSTR while not valid)
//   if_id_pc_plus2   PC+2 of that instruction, the branch base
//   halted           front end parked on HLT
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INSTR   = 16'h0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [15:0]         redirect_pc,
  fetch_stage_if.master       imem,
  output logic                if_id_valid,
  output logic [15:0]         if_id_instr,
  output logic [15:0]         if_id_pc_plus2,
  output logic                halted
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic        if_id_valid_q, if_id_valid_d;
  logic [15:0] if_id_instr_q, if_id_instr_d;
  logic [15:0] if_id_pc_plus2_q, if_id_pc_plus2_d;
  logic        halted_q, halted_d;

  logic [15:0] pc_plus2;
  logic [15:0] redirect_target;

  // Addition wraps mod 2^16: 16'hFFFE + 2 gives 16'h0000.
  assign pc_plus2        = pc_q + 16'd2;
  // Bit 0 is cleared, so the PC always stays halfword aligned.
  assign redirect_target = redirect_pc & 16'hFFFE;

  always_comb begin
    // NOTE: every signal gets a default before the case statement. This
    // avoids inferred latches and makes "hold" the implicit behaviour.
    state_d          = state_q;
    pc_d             = pc_q;
    if_id_valid_d    = if_id_valid_q;
    if_id_instr_d    = if_id_instr_q;
    if_id_pc_plus2_d = if_id_pc_plus2_q;
    halted_d         = halted_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (redirect_valid) begin
          // The wrong-path word, if one returns this cycle, is discarded.
          pc_d          = redirect_target;
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP_INSTR;
        end else if (stall) begin
          // Hold everything. Returned data is dropped and fetched again later.
        end else if (imem.imem_ready) begin
          if_id_valid_d    = 1'b1;
          if_id_instr_d    = imem.imem_rdata;
          if_id_pc_plus2_d = pc_plus2;
          if (imem.imem_rdata[15:12] == HALT_OPCODE) begin
            // HLT enters decode, but the PC stays on it.
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_plus2;
          end
        end else begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP_INSTR;
        end
      end

      ST_HALT: begin
        if (redirect_valid) begin
          // The HLT was on a mispredicted path, so resume at the target.
          state_d       = ST_FETCH;
          halted_d      = 1'b0;
          pc_d          = redirect_target;
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP_INSTR;
        end else if (!stall) begin
          if_id_valid_d = 1'b0;
          if_id_instr_d = NOP_INSTR;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      pc_q             <= RESET_PC;
      if_id_valid_q    <= 1'b0;
      if_id_instr_q    <= NOP_INSTR;
      if_id_pc_plus2_q <= 16'h0000;
      halted_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      if_id_valid_q    <= if_id_valid_d;
      if_id_instr_q    <= if_id_instr_d;
      if_id_pc_plus2_q <= if_id_pc_plus2_d;
      halted_q         <= halted_d;
    end
  end

  assign imem.imem_req   = (state_q == ST_FETCH);
  assign imem.imem_addr  = pc_q;
  assign if_id_valid     = if_id_valid_q;
  assign if_id_instr     = if_id_instr_q;
  assign if_id_pc_plus2  = if_id_pc_plus2_q;
  assign halted          = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        halted;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (bus),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Expected IF/ID contents {instr, pc_plus2}, one entry per cycle that IF/ID is valid.
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the inputs for one cycle, then return 1 time unit after the edge.
  task automatic step(input logic rdy, input logic [15:0] rd, input logic stl,
                      input logic rv, input logic [15:0] rp);
    bus.imem_ready  = rdy;
    bus.imem_rdata  = rd;
    stall           = stl;
    redirect_valid  = rv;
    redirect_pc     = rp;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [15:0] instr, input logic [15:0] pc2);
    exp_q.push_back({instr, pc2});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"},  {31'd0, if_id_valid},   32'd0);
    check({tag, "_instr"},  {16'd0, if_id_instr},   32'd0);
    check({tag, "_pc2"},    {16'd0, if_id_pc_plus2}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted},        32'd0);
    check({tag, "_req"},    {31'd0, bus.imem_req},  32'd0);
    check({tag, "_addr"},   {16'd0, bus.imem_addr}, 32'd0);
  endtask

  // Scoreboard monitor: samples IF/ID on the falling edge, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (if_id_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL sb_unexpected: got instr 0x%0h pc2 0x%0h, expected no valid word at %0t",
                   if_id_instr, if_id_pc_plus2, $time);
        end else begin
          check("sb_ifid", {if_id_instr, if_id_pc_plus2}, exp_q.pop_front());
        end
      end else if (rst_n === 1'b1) begin
        check("sb_bubble_nop", {16'd0, if_id_instr}, 32'h0000);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check_reset_values("rst");
    rst_n = 1'b1;
    // IDLE -> FETCH
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("idle_to_fetch_req", {31'd0, bus.imem_req}, 32'd1);
    check("idle_to_fetch_addr", {16'd0, bus.imem_addr}, 32'h0000);

    // 1: back-to-back fetches
    expect_word(16'h1111, 16'h0002);
    step(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0);
    check("t1_addr0", {16'd0, bus.imem_addr}, 32'h0002);
    expect_word(16'h2222, 16'h0004);
    step(1'b1, 16'h2222, 1'b0, 1'b0, 16'h0);
    check("t1_addr1", {16'd0, bus.imem_addr}, 32'h0004);

    // 2: three wait states at 0x0010
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0010);
    check("t2_redir_addr", {16'd0, bus.imem_addr}, 32'h0010);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'hBAD0, 1'b0, 1'b0, 16'h0);
      check("t2_wait_valid", {31'd0, if_id_valid}, 32'd0);
      check("t2_wait_addr", {16'd0, bus.imem_addr}, 32'h0010);
    end
    expect_word(16'h3333, 16'h0012);
    step(1'b1, 16'h3333, 1'b0, 1'b0, 16'h0);
    check("t2_addr_after", {16'd0, bus.imem_addr}, 32'h0012);

    // 3: two stalled cycles with data returning; IF/ID stays frozen
    for (int i = 0; i < 2; i++) begin
      expect_word(16'h3333, 16'h0012);
      step(1'b1, 16'h4444, 1'b1, 1'b0, 16'h0);
      check("t3_stall_addr", {16'd0, bus.imem_addr}, 32'h0012);
    end
    expect_word(16'h4444, 16'h0014);
    step(1'b1, 16'h4444, 1'b0, 1'b0, 16'h0);
    check("t3_refetch_addr", {16'd0, bus.imem_addr}, 32'h0014);

    // 4: redirect beats stall and the returned data; bit 0 of the target is cleared
    step(1'b1, 16'h5555, 1'b1, 1'b1, 16'h0041);
    check("t4_addr", {16'd0, bus.imem_addr}, 32'h0040);
    check("t4_valid", {31'd0, if_id_valid}, 32'd0);

    // 5: HLT at 0x0020, then redirect out of the halt
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0020);
    expect_word(16'hF000, 16'h0022);
    step(1'b1, 16'hF000, 1'b0, 1'b0, 16'h0);
    check("t5_halted", {31'd0, halted}, 32'd1);
    check("t5_req", {31'd0, bus.imem_req}, 32'd0);
    check("t5_addr", {16'd0, bus.imem_addr}, 32'h0020);
    step(1'b1, 16'h9999, 1'b0, 1'b0, 16'h0);
    check("t5_park_valid", {31'd0, if_id_valid}, 32'd0);
    check("t5_park_halted", {31'd0, halted}, 32'd1);
    check("t5_park_addr", {16'd0, bus.imem_addr}, 32'h0020);
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'h0100);
    check("t5_unhalt", {31'd0, halted}, 32'd0);
    check("t5_req_back", {31'd0, bus.imem_req}, 32'd1);
    check("t5_resume_addr", {16'd0, bus.imem_addr}, 32'h0100);
    expect_word(16'h6666, 16'h0102);
    step(1'b1, 16'h6666, 1'b0, 1'b0, 16'h0);
    check("t5_next_addr", {16'd0, bus.imem_addr}, 32'h0102);

    // 6: PC wraps from 0xFFFE, then reset is asserted while a fetch is waiting
    step(1'b0, 16'h0, 1'b0, 1'b1, 16'hFFFE);
    expect_word(16'h7777, 16'h0000);
    step(1'b1, 16'h7777, 1'b0, 1'b0, 16'h0);
    check("t6_wrap_addr", {16'd0, bus.imem_addr}, 32'h0000);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("t6_async");
    step(1'b1, 16'h8888, 1'b0, 1'b0, 16'h0);
    check_reset_values("t6_held");
    rst_n = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("t6_restart_req", {31'd0, bus.imem_req}, 32'd1);
    check("t6_restart_addr", {16'd0, bus.imem_addr}, 32'h0000);

    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
